// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg
//   Definitions shared by every inter-stage buffer: the packed stage record
//   that travels between pipeline stages, and the default buffer geometry.
//   Stage buffers import this package rather than redefining field layouts.
package pipe_stage_buf_pkg;

    // Packed stage record (pc, opcode, register indices, operands, control).
    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] opnd_a;
        logic [31:0] opnd_b;
        logic [23:0] imm;
        logic [7:0]  ctrl;
    } stage_rec_t;

    localparam int PSB_WIDTH  = $bits(stage_rec_t);    // 150
    localparam int PSB_DEPTH  = 2;                      // power of two, >= 2
    localparam int PSB_ADDR_B = $clog2(PSB_DEPTH);

endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if
//   Handshake bundle between an upstream stage, the inter-stage buffer and the
//   downstream stage.
//   Ports (signals):
//     wr_req/wr_data  -> buffer      upstream write request + payload
//     wr_ack          <- buffer      one-cycle write accept pulse
//     rd_req          -> buffer      downstream read request
//     rd_ack/rd_data  <- buffer      one-cycle read accept pulse + head payload
//     flush_req       -> buffer      redirect flush request
//     flush_ack       <- buffer      one-cycle flush done pulse
//     avail/count     <- buffer      non-empty flag / occupancy
//   Modports: master (stage side), slave (buffer side).
interface pipe_stage_buf_if
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = PSB_WIDTH,
    parameter int DEPTH = PSB_DEPTH
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_req;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;
    logic             avail;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ack;
    logic             flush_req;
    logic             flush_ack;
    logic [CNT_W-1:0] count;

    modport master (
        output wr_req, wr_data, rd_req, flush_req,
        input  wr_ack, avail, rd_data, rd_ack, flush_ack, count
    );

    modport slave (
        input  wr_req, wr_data, rd_req, flush_req,
        output wr_ack, avail, rd_data, rd_ack, flush_ack, count
    );

endinterface

// File: rtl/pipe_stage_buf_mem.sv
// pipe_stage_buf_mem
//   DEPTH x WIDTH register array with one write port and one registered read
//   port. The read register holds its value until the next read enable.
//   Ports:
//     clk, rst        clock, async active-high reset (clears read register only)
//     we/waddr/wdata  write port, takes effect at the rising edge
//     re/raddr        read enable / index; rdata loads mem[raddr] at the edge
//     rdata           registered read data
module pipe_stage_buf_mem
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = PSB_WIDTH,
    parameter int DEPTH = PSB_DEPTH,
    localparam int ADDR_B = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_B-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_B-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        // Reads see the array as it was at the start of the cycle: no bypass.
        rd_data_d = re ? mem_q[raddr] : rd_data_q;
    end

    // Storage array is not reset; only valid entries are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Responder end of the inter-stage buffer handshake: a small circular FIFO
//   between pipeline stages, emptied by a branch/jump redirect flush.
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   pipe_stage_buf_if.slave (write, read and flush handshakes,
//           avail/count status); all outputs are registered.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = PSB_WIDTH,
    parameter int DEPTH = PSB_DEPTH
) (
    input logic           clk,
    input logic           rst,
    pipe_stage_buf_if.slave bus
);
    localparam int ADDR_B = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_B + 1;

    logic [CNT_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             rd_ack_q, rd_ack_d;
    logic             flush_ack_q, flush_ack_d;
    logic             avail_q, avail_d;

    logic full, empty;
    logic wr_go, rd_go, flush_go;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A pending flush blocks both transfers; an ack still high blocks a repeat
    // accept of the same request. A read freeing a slot does not admit a
    // write in the same cycle because 'full' is the registered count.
    assign flush_go = bus.flush_req & ~flush_ack_q;
    assign wr_go    = bus.wr_req & ~wr_ack_q & ~full  & ~bus.flush_req;
    assign rd_go    = bus.rd_req & ~rd_ack_q & ~empty & ~bus.flush_req;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        wr_ack_d    = wr_go;
        rd_ack_d    = rd_go;
        flush_ack_d = flush_go;

        if (wr_go) begin
            wptr_d = wptr_q + CNT_W'(1);
        end
        if (rd_go) begin
            rptr_d = rptr_q + CNT_W'(1);
        end
        case ({wr_go, rd_go})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush_go) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end

        avail_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            flush_ack_q <= 1'b0;
            avail_q     <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            rd_ack_q    <= rd_ack_d;
            flush_ack_q <= flush_ack_d;
            avail_q     <= avail_d;
        end
    end

    pipe_stage_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_go),
        .waddr (wptr_q[ADDR_B-1:0]),
        .wdata (bus.wr_data),
        .re    (rd_go),
        .raddr (rptr_q[ADDR_B-1:0]),
        .rdata (bus.rd_data)
    );

    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.flush_ack = flush_ack_q;
    assign bus.avail     = avail_q;
    assign bus.count     = count_q;

    // A full buffer never advances the write pointer, an empty one never
    // advances the read pointer (flush aside, which zeroes both).
    a_no_wr_when_full: assert property (@(posedge clk) disable iff (rst)
        (full && !flush_go) |=> (wptr_q == $past(wptr_q)));
    a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rst)
        (empty && !flush_go) |=> (rptr_q == $past(rptr_q)));

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
   import pipe_stage_buf_pkg::*;

   localparam int W     = PSB_WIDTH;
   localparam int D     = PSB_DEPTH;
   localparam int CNT_W = $clog2(D) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipe_stage_buf_if #(.WIDTH(W), .DEPTH(D)) bus ();

   pipe_stage_buf #(.WIDTH(W), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input bit ok);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $error("FAIL %s", tag);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   task automatic do_write(input logic [W-1:0] d, output int cyc);
      cyc = 0;
      bus.wr_req  = 1'b1;
      bus.wr_data = d;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.wr_ack !== 1'b1 && cyc < 20);
      chk("wr_ack_seen", bus.wr_ack === 1'b1);
      bus.wr_req = 1'b0;
   endtask

   task automatic do_read(input logic [W-1:0] exp, output int cyc);
      cyc = 0;
      bus.rd_req = 1'b1;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.rd_ack !== 1'b1 && cyc < 20);
      chk("rd_ack_seen", bus.rd_ack === 1'b1);
      chk("rd_data", bus.rd_data === exp);
      bus.rd_req = 1'b0;
   endtask

   logic [W-1:0] q[$];
   logic         e_wack, e_rack, e_fack;
   logic [W-1:0] e_rdata;

   initial begin
      int cyc;
      logic [W-1:0] va, vb, vc, vx, vy, vp, vq, vr;
      logic m_full, m_empty, m_wgo, m_rgo, m_fgo;

      bus.wr_req    = 1'b0;
      bus.wr_data   = '0;
      bus.rd_req    = 1'b0;
      bus.flush_req = 1'b0;

      @(negedge clk);
      chk("rst_wr_ack", bus.wr_ack === 1'b0);
      chk("rst_rd_ack", bus.rd_ack === 1'b0);
      chk("rst_flush_ack", bus.flush_ack === 1'b0);
      chk("rst_count", bus.count === CNT_W'(0));
      chk("rst_avail", bus.avail === 1'b0);
      chk("rst_rd_data", bus.rd_data === W'(0));
      rst = 1'b0;
      @(negedge clk);

      bus.wr_req  = 1'b1;
      bus.wr_data = W'('hABCD);
      @(posedge clk);
      #1;
      chk("mid_wr_ack_pre", bus.wr_ack === 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_ack", bus.wr_ack === 1'b0);
      chk("mid_rst_count", bus.count === CNT_W'(0));
      chk("mid_rst_avail", bus.avail === 1'b0);
      chk("mid_rst_rd_data", bus.rd_data === W'(0));
      @(negedge clk);
      chk("mid_rst_hold_wr_ack", bus.wr_ack === 1'b0);
      chk("mid_rst_hold_count", bus.count === CNT_W'(0));
      bus.wr_req = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      do_write(W'('h1234), cyc);
      chk("single_wr_latency", cyc == 1);
      chk("single_avail", bus.avail === 1'b1);
      chk("single_count1", bus.count === CNT_W'(1));
      @(negedge clk);
      chk("single_wr_ack_pulse", bus.wr_ack === 1'b0);
      do_read(W'('h1234), cyc);
      chk("single_rd_latency", cyc == 1);
      chk("single_count0", bus.count === CNT_W'(0));
      chk("single_avail0", bus.avail === 1'b0);
      @(negedge clk);
      chk("single_rd_ack_pulse", bus.rd_ack === 1'b0);

      va = rand_word(); vb = rand_word(); vc = rand_word();
      do_write(va, cyc);
      do_write(vb, cyc);
      chk("fill_count2", bus.count === CNT_W'(2));
      bus.wr_req  = 1'b1;
      bus.wr_data = vc;
      repeat (3) begin
         @(negedge clk);
         chk("fill_stall_wr_ack", bus.wr_ack === 1'b0);
         chk("fill_stall_count", bus.count === CNT_W'(2));
      end
      bus.rd_req = 1'b1;
      @(negedge clk);
      chk("fill_rd_ack", bus.rd_ack === 1'b1);
      chk("fill_rd_a", bus.rd_data === va);
      chk("fill_no_same_cycle_wr", bus.wr_ack === 1'b0);
      chk("fill_count1", bus.count === CNT_W'(1));
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("fill_late_wr_ack", bus.wr_ack === 1'b1);
      chk("fill_count2b", bus.count === CNT_W'(2));
      bus.wr_req = 1'b0;
      do_read(vb, cyc);
      do_read(vc, cyc);
      chk("fill_count0", bus.count === CNT_W'(0));

      for (int v = 1; v <= 10; v++) begin
         do_write(W'(v), cyc);
         chk("wrap_count_w", bus.count === CNT_W'(1));
         do_read(W'(v), cyc);
         chk("wrap_count_r", bus.count === CNT_W'(0));
      end

      vx = rand_word(); vy = rand_word();
      do_write(vx, cyc);
      @(negedge clk);
      bus.wr_req  = 1'b1;
      bus.wr_data = vy;
      bus.rd_req  = 1'b1;
      @(negedge clk);
      chk("conc_wr_ack", bus.wr_ack === 1'b1);
      chk("conc_rd_ack", bus.rd_ack === 1'b1);
      chk("conc_rd_data", bus.rd_data === vx);
      chk("conc_count", bus.count === CNT_W'(1));
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      @(negedge clk);
      do_read(vy, cyc);

      vp = rand_word(); vq = rand_word(); vr = rand_word();
      do_write(vp, cyc);
      do_write(vq, cyc);
      chk("flush_pre_count", bus.count === CNT_W'(2));
      bus.flush_req = 1'b1;
      bus.wr_req    = 1'b1;
      bus.wr_data   = vr;
      @(negedge clk);
      chk("flush_ack", bus.flush_ack === 1'b1);
      chk("flush_wr_blocked", bus.wr_ack === 1'b0);
      chk("flush_count", bus.count === CNT_W'(0));
      chk("flush_avail", bus.avail === 1'b0);
      chk("flush_keeps_rd_data", bus.rd_data === vy);
      bus.flush_req = 1'b0;
      @(negedge clk);
      chk("flush_post_wr_ack", bus.wr_ack === 1'b1);
      chk("flush_post_count", bus.count === CNT_W'(1));
      chk("flush_ack_pulse", bus.flush_ack === 1'b0);
      bus.wr_req = 1'b0;
      do_read(vr, cyc);
      @(negedge clk);

      q.delete();
      e_wack  = 1'b0;
      e_rack  = 1'b0;
      e_fack  = 1'b0;
      e_rdata = vr;
      for (int c = 0; c < 400; c++) begin
         if (bus.wr_req && e_wack) bus.wr_req = 1'b0;
         else if (!bus.wr_req && $urandom_range(0, 2) == 0) begin
            bus.wr_req  = 1'b1;
            bus.wr_data = rand_word();
         end
         if (bus.rd_req && e_rack) bus.rd_req = 1'b0;
         else if (!bus.rd_req && $urandom_range(0, 2) == 0) bus.rd_req = 1'b1;
         if (bus.flush_req && e_fack) bus.flush_req = 1'b0;
         else if (!bus.flush_req && $urandom_range(0, 24) == 0) bus.flush_req = 1'b1;

         m_full  = (q.size() == D);
         m_empty = (q.size() == 0);
         m_fgo   = bus.flush_req && !e_fack;
         m_wgo   = bus.wr_req && !e_wack && !m_full && !bus.flush_req;
         m_rgo   = bus.rd_req && !e_rack && !m_empty && !bus.flush_req;
         if (m_rgo) e_rdata = q.pop_front();
         if (m_wgo) q.push_back(bus.wr_data);
         if (m_fgo) q.delete();
         e_wack = m_wgo;
         e_rack = m_rgo;
         e_fack = m_fgo;

         @(negedge clk);
         chk("rnd_wr_ack", bus.wr_ack === e_wack);
         chk("rnd_rd_ack", bus.rd_ack === e_rack);
         chk("rnd_flush_ack", bus.flush_ack === e_fack);
         chk("rnd_count", bus.count === CNT_W'(q.size()));
         chk("rnd_avail", bus.avail === (q.size() != 0));
         chk("rnd_rd_data", bus.rd_data === e_rdata);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
